imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for instruction memory; the CPU only ever reads instruction memory.
- Receives a byte stream (valid/ready), assembles big-endian 32-bit words and writes them to consecutive word-aligned addresses starting at 0.
- Holds the CPU in reset via cpu_hold until the image is fully loaded.
- Sits between an external byte source (UART RX or bench) and the instruction memory write port.

Parameters:
- MAX_WORDS, 256, maximum accepted word count; a header count N > MAX_WORDS is an error; legal range 1..65535.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; the block is in reset while rst=0.
- byte_valid  input  1  source has a byte on byte_data.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- wr_en  output  1  instruction memory write strobe, one-cycle pulse per word.
- wr_addr  output  32  byte address of the write; always word-aligned, equals word index × 4.
- wr_data  output  32  assembled word.
- cpu_hold  output  1  1 = keep CPU in reset.
- done  output  1  load completed successfully.
- error  output  1  load aborted.

Behaviour:
- Byte transfer occurs on a rising edge where byte_valid=1 and byte_ready=1; no other byte is consumed.
- Stream format:
  - 2-byte word count N, big-endian.
  - Then N words of 4 bytes each, most significant byte first.
  - First data word goes to address 0.
- States: LEN_HI, LEN_LO, DATA, WRITE, [CSUM], DONE, ERR.
- Reset (rst=0, asynchronous):
  - state=LEN_HI; armed=0; word index=0; byte counter=0.
  - wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, byte_ready=0.
- armed is set on the first rising edge with rst=1.
- byte_ready = armed AND state in {LEN_HI, LEN_LO, DATA, CSUM}; it is 0 in WRITE, DONE and ERR.
- State transitions:
  - LEN_HI: on transfer, latch N[15:8] -> LEN_LO.
  - LEN_LO: on transfer, latch N[7:0].
    - N=0 -> DONE (or CSUM when the feature is enabled).
    - N > MAX_WORDS -> ERR.
    - Otherwise -> DATA.
  - DATA: shift in bytes (wr_data <= {wr_data[23:0], byte}). On the 4th byte transfer -> WRITE.
  - WRITE: exactly one cycle.
    - wr_en=1, wr_addr=index×4, wr_data=assembled word.
    - Next edge: index+1, byte counter=0.
    - If index+1 = N -> DONE (or CSUM), else -> DATA.
- Throughput: minimum 5 cycles per word; wr_en is asserted in the cycle immediately after the 4th byte's edge.
- wr_addr and wr_data hold their last values outside WRITE; wr_en is 0 outside WRITE.
- DONE: cpu_hold=0, done=1. Sticky until reset; further bytes are not consumed.
- ERR: cpu_hold=1, error=1. Sticky until reset; no writes; bytes not consumed.
- cpu_hold, done and error are registered and change on the edge entering DONE/ERR.
- Reset mid-load: all partial state is discarded, and the next load restarts at LEN_HI / address 0.
- byte_valid asserted while byte_ready=0 (WRITE cycle): the byte is not consumed and must be held by the source.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the final word (or N=0), state CSUM accepts one byte.
  - The byte must equal the XOR of all payload data bytes (header excluded; 0x00 when N=0).
  - Match -> DONE; mismatch -> ERR.
  - Running XOR resets to 0 on reset.
- Undefined:
  - No CSUM state and no XOR register.
  - After the last WRITE -> DONE directly; no trailing byte is consumed.

Test Plan:
- Reset, stream 00 02 20 08 00 05 AC 01 00 04 -> wr_en pulses: (0x00000000, 0x20080005) then (0x00000004, 0xAC010004); done=1 and cpu_hold=0 from the edge after the 2nd pulse; no further bytes consumed.
- Stream 00 00 (checksum disabled) -> no wr_en; done=1 one edge after LEN_LO transfer.
- MAX_WORDS=256, stream 01 01 -> error=1, cpu_hold=1, byte_ready=0, no wr_en; subsequent bytes ignored until reset.
- Stream of case 1 with 0-3 random idle cycles between bytes, and byte_valid held through each WRITE cycle -> identical writes; the byte presented during WRITE is consumed on the following edge.
- After 00 01 12 34, pulse rst low mid-cycle -> outputs immediately at reset values; new stream 00 01 DE AD BE EF -> single write (0x00000000, 0xDEADBEEF).
- With IMEM_LOADER_CHECKSUM_EN, stream 00 01 12 34 56 78 08 -> write 0x12345678 at 0, then done=1; same stream ending 09 -> error=1, cpu_hold=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if -- byte-stream handshake between a byte source (UART RX,
// bench) and the instruction-memory loader.
//   byte_valid : source has a byte on byte_data
//   byte_data  : stream byte
//   byte_ready : loader can accept a byte this cycle
// A byte moves on a rising edge where byte_valid and byte_ready are both 1.
// master = byte source, slave = loader.
interface imem_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader -- boot-time writer for instruction memory.
// Consumes a byte stream: a 2-byte big-endian word count N, then N words of
// 4 bytes each (MSB first). It writes each word to byte address index*4,
// starting at 0. cpu_hold stays high until the image is fully loaded.
//
// Ports:
//   clk      : single clock, rising edge
//   rst      : asynchronous active-low reset
//   bs       : byte-stream handshake (imem_loader_if.slave)
//   wr_en    : one-cycle write strobe per word
//   wr_addr  : word-aligned byte address of the write
//   wr_data  : assembled word
//   cpu_hold : 1 = keep the CPU in reset
//   done     : load completed successfully (sticky)
//   error    : load aborted (sticky)
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When it is defined, one
// trailing byte follows the payload. That byte must equal the XOR of all
// payload bytes (0x00 when N=0).
module imem_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst,
  imem_loader_if.slave        bs,
  output logic                wr_en,
  output logic [31:0]         wr_addr,
  output logic [31:0]         wr_data,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;
`endif

  state_t      state_q, state_d;
  logic        armed_q;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        ready;
  logic        xfer;
  logic [15:0] n_full;
  logic [15:0] idx_inc;

  assign ready   = armed_q && (state_q == S_LEN_HI || state_q == S_LEN_LO ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                               state_q == S_CSUM ||
`endif
                               state_q == S_DATA);
  assign xfer    = bs.byte_valid && ready;
  assign n_full  = {len_q[15:8], bs.byte_data};
  assign idx_inc = idx_q + 16'd1;

  assign bs.byte_ready = ready;
  assign wr_en         = (state_q == S_WRITE);
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign cpu_hold      = cpu_hold_q;
  assign done          = done_q;
  assign error         = error_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    error_d    = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = bs.byte_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = bs.byte_data;
          if (n_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d    = S_CSUM;
`else
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
`endif
          end else if ({16'd0, n_full} > $unsigned(MAX_WORDS)) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          wr_data_d = {wr_data_q[23:0], bs.byte_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d    = csum_q ^ bs.byte_data;
`endif
          if (bcnt_q == 2'd3) begin
            // Latch the address now so it stays stable through and after WRITE.
            wr_addr_d = {14'd0, idx_q, 2'b00};
            state_d   = S_WRITE;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        idx_d  = idx_inc;
        bcnt_d = 2'd0;
        if (idx_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d    = S_CSUM;
`else
          state_d    = S_DONE;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          if (bs.byte_data == csum_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
`endif
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LEN_HI;
      armed_q    <= 1'b0;
      len_q      <= 16'd0;
      idx_q      <= 16'd0;
      bcnt_q     <= 2'd0;
      wr_addr_q  <= 32'd0;
      wr_data_q  <= 32'd0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      armed_q    <= 1'b1;
      len_q      <= len_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader. Inputs are driven on the falling edge,
// and outputs are sampled on the falling edge.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  always #5 clk = ~clk;

  imem_loader_if bif ();

  imem_loader #(.MAX_WORDS(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .bs       (bif),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  // Record every write strobe.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte after 'idle' idle cycles. Wait (bounded) for ready,
  // then let one rising edge consume it. The task returns on the following
  // falling edge. 'stalls' counts the cycles the byte waited for ready.
  task automatic send_byte(input logic [7:0] b, input int idle, output int stalls);
    stalls = 0;
    repeat (idle) @(negedge clk);
    bif.byte_valid = 1'b1;
    bif.byte_data  = b;
    while (bif.byte_ready !== 1'b1 && stalls < 20) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 20) begin
      chk("byte_accept_timeout", {31'd0, bif.byte_ready}, 32'd1);
      bif.byte_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bif.byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bif.byte_valid = 1'b0;
    @(negedge clk);
    wq_addr.delete();
    wq_data.delete();
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Hold a byte on the bus for n cycles and require that it is never accepted.
  task automatic hold_ignored(input string tag, input int n);
    bif.byte_valid = 1'b1;
    bif.byte_data  = 8'h55;
    for (int k = 0; k < n; k++) begin
      chk(tag, {31'd0, bif.byte_ready}, 32'd0);
      @(negedge clk);
    end
    bif.byte_valid = 1'b0;
  endtask

  logic [7:0] s1 [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                          8'hAC, 8'h01, 8'h00, 8'h04};
  logic [7:0] s5 [6]  = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
  int st;
  int st6;

  initial begin
    rst = 1'b0;
    bif.byte_valid = 1'b0;
    bif.byte_data  = 8'h00;

    // Reset state
    @(negedge clk);
    chk("rst_wr_en",    {31'd0, wr_en},    32'd0);
    chk("rst_wr_addr",  wr_addr,           32'd0);
    chk("rst_wr_data",  wr_data,           32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_error",    {31'd0, error},    32'd0);
    chk("rst_ready",    {31'd0, bif.byte_ready}, 32'd0);
    rst = 1'b1;
    #1 chk("unarmed_ready", {31'd0, bif.byte_ready}, 32'd0);
    @(negedge clk);
    chk("armed_ready", {31'd0, bif.byte_ready}, 32'd1);

    // Test 1: two-word image, back-to-back bytes
    st6 = -1;
    for (int i = 0; i < 10; i++) begin
      send_byte(s1[i], 0, st);
      if (i == 6) st6 = st;
    end
    chk("t1_write_stall", st6, 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h84, 0, st);
`else
    chk("t1_wr_en_2nd", {31'd0, wr_en}, 32'd1);
    chk("t1_done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
`endif
    chk("t1_done",     {31'd0, done},     32'd1);
    chk("t1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t1_error",    {31'd0, error},    32'd0);
    hold_ignored("t1_ready_after_done", 3);
    chk("t1_nwrites", wq_addr.size(), 32'd2);
    if (wq_addr.size() == 2) begin
      chk("t1_addr0", wq_addr[0], 32'h0000_0000);
      chk("t1_data0", wq_data[0], 32'h2008_0005);
      chk("t1_addr1", wq_addr[1], 32'h0000_0004);
      chk("t1_data1", wq_data[1], 32'hAC01_0004);
    end
    chk("t1_addr_hold", wr_addr, 32'h0000_0004);
    chk("t1_data_hold", wr_data, 32'hAC01_0004);

    // Test 2: empty image
    do_reset();
    send_byte(8'h00, 0, st);
    send_byte(8'h00, 0, st);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("t2_done_before_csum", {31'd0, done}, 32'd0);
    send_byte(8'h00, 0, st);
`endif
    chk("t2_done",     {31'd0, done},     32'd1);
    chk("t2_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t2_nwrites",  wq_addr.size(),    32'd0);

    // Test 3: count 257 exceeds MAX_WORDS
    do_reset();
    send_byte(8'h01, 0, st);
    send_byte(8'h01, 0, st);
    chk("t3_error",    {31'd0, error},    32'd1);
    chk("t3_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t3_done",     {31'd0, done},     32'd0);
    hold_ignored("t3_ready_in_err", 4);
    chk("t3_nwrites",     wq_addr.size(),  32'd0);
    chk("t3_error_stick", {31'd0, error},  32'd1);

    // Test 4: same image with idle gaps; the first byte of word 2 is held through WRITE
    do_reset();
    st6 = -1;
    for (int i = 0; i < 10; i++) begin
      send_byte(s1[i], (i == 6) ? 0 : int'($urandom_range(0, 3)), st);
      if (i == 6) st6 = st;
    end
    chk("t4_write_stall", st6, 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h84, 1, st);
`else
    @(negedge clk);
`endif
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_nwrites", wq_addr.size(), 32'd2);
    if (wq_addr.size() == 2) begin
      chk("t4_addr0", wq_addr[0], 32'h0000_0000);
      chk("t4_data0", wq_data[0], 32'h2008_0005);
      chk("t4_addr1", wq_addr[1], 32'h0000_0004);
      chk("t4_data1", wq_data[1], 32'hAC01_0004);
    end

    // Test 5: reset mid-load, then reload
    do_reset();
    send_byte(8'h00, 0, st);
    send_byte(8'h01, 0, st);
    send_byte(8'h12, 0, st);
    send_byte(8'h34, 0, st);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_wr_data",  wr_data,           32'd0);
    chk("t5_rst_wr_addr",  wr_addr,           32'd0);
    chk("t5_rst_ready",    {31'd0, bif.byte_ready}, 32'd0);
    chk("t5_rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t5_rst_done",     {31'd0, done},     32'd0);
    @(negedge clk);
    wq_addr.delete();
    wq_data.delete();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) send_byte(s5[i], 0, st);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h22, 0, st);
`else
    @(negedge clk);
`endif
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_nwrites", wq_addr.size(), 32'd1);
    if (wq_addr.size() == 1) begin
      chk("t5_addr0", wq_addr[0], 32'h0000_0000);
      chk("t5_data0", wq_data[0], 32'hDEAD_BEEF);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Test 6: checksum match and mismatch
    do_reset();
    send_byte(8'h00, 0, st);
    send_byte(8'h01, 0, st);
    send_byte(8'h12, 0, st);
    send_byte(8'h34, 0, st);
    send_byte(8'h56, 0, st);
    send_byte(8'h78, 0, st);
    send_byte(8'h08, 0, st);
    chk("t6_done",  {31'd0, done},  32'd1);
    chk("t6_error", {31'd0, error}, 32'd0);
    chk("t6_nwrites", wq_addr.size(), 32'd1);
    if (wq_addr.size() == 1) begin
      chk("t6_addr0", wq_addr[0], 32'h0000_0000);
      chk("t6_data0", wq_data[0], 32'h1234_5678);
    end
    do_reset();
    send_byte(8'h00, 0, st);
    send_byte(8'h01, 0, st);
    send_byte(8'h12, 0, st);
    send_byte(8'h34, 0, st);
    send_byte(8'h56, 0, st);
    send_byte(8'h78, 0, st);
    send_byte(8'h09, 0, st);
    chk("t6_bad_error",    {31'd0, error},    32'd1);
    chk("t6_bad_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t6_bad_done",     {31'd0, done},     32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
